// File: rtl/if_id_skid_reg_pkg.sv
// Shared pipeline package: datapath width, bubble constants, the
// {instr, pc, valid} bundle reused by stage registers, and the IF/ID
// occupancy state encoding.
package if_id_skid_reg_pkg;

   localparam int                   PIPE_XLEN      = 32;
   localparam logic [PIPE_XLEN-1:0] PIPE_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [PIPE_XLEN-1:0] PIPE_BUBBLE_PC = 32'h0000_0000;

   // One in-flight instruction as carried between pipeline stages.
   typedef struct packed {
      logic [PIPE_XLEN-1:0] instr;
      logic [PIPE_XLEN-1:0] pc;
      logic                 valid;
   } ifid_t;

   // Encoding mirrors {skid_valid, out_valid}.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b11
   } ifid_state_e;

endpackage

// File: rtl/if_id_skid_reg_pipe_skid_entry.sv
// pipe_skid_entry: single holding register with load / clear and a valid
// flag. Only the valid flag is reset; the payload is don't-care while
// valid is low.
module pipe_skid_entry
   import if_id_skid_reg_pkg::*;
#(
   parameter type T = ifid_t
)(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   input  T     d,
   output T     q,
   output logic valid
);

   // Occupancy flag: clear wins over load.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end
   end

   // Payload capture.
   always_ff @(posedge clk) begin
      if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID boundary register with a one-entry skid buffer.
// The stall returned to fetch is the skid occupancy flag, so there is no
// combinational path from id_stall to if_stall_o.
// Optional: define IFID_PERF_CNT_EN to add perf_stall_cnt / perf_bubble_cnt.
module if_id_skid_reg
   import if_id_skid_reg_pkg::*;
#(
   parameter int              XLEN      = PIPE_XLEN,
   parameter logic [XLEN-1:0] NOP_INSTR = PIPE_NOP_INSTR,
   parameter logic [XLEN-1:0] BUBBLE_PC = PIPE_BUBBLE_PC
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_valid,
   output logic            if_stall_o,
   input  logic            id_stall,
   input  logic            id_flush,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc4,
   output logic            id_valid
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [31:0]     perf_stall_cnt,
   output logic [31:0]     perf_bubble_cnt
`endif
);

   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

   ifid_state_e     state_q, state_d;

   ifid_t           skid_d_p0, skid_q_p1;
   logic            skid_valid;
   logic            skid_load, skid_clear;

   logic            out_load;
   logic [XLEN-1:0] instr_d, pc_d, pc4_d;
   logic            valid_d;

   // Skid entry: parks the instruction fetched during the first stall cycle.
   pipe_skid_entry #(.T(ifid_t)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (skid_d_p0),
      .q     (skid_q_p1),
      .valid (skid_valid)
   );

   assign if_stall_o = skid_valid;

   // Next-state, skid control and output-register next values (priority flush > stall > advance).
   always_comb begin
      state_d    = state_q;
      out_load   = 1'b0;
      instr_d    = id_instr;
      pc_d       = id_pc;
      pc4_d      = id_pc4;
      valid_d    = id_valid;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      skid_d_p0  = '{instr: if_instr, pc: if_pc, valid: if_valid};

      if (id_flush) begin
         out_load   = 1'b1;
         instr_d    = NOP_INSTR;
         pc_d       = BUBBLE_PC;
         pc4_d      = pc_plus4(BUBBLE_PC);
         valid_d    = 1'b0;
         skid_clear = 1'b1;
         state_d    = ST_EMPTY;
      end else if (id_stall) begin
         // Output holds; a full skid means fetch is already stalled and if_* is stale.
         if (!skid_valid && if_valid) begin
            skid_load = 1'b1;
            if (state_q == ST_FULL) begin
               state_d = ST_SKID;
            end
         end
      end else if (skid_valid) begin
         // Drain the skid first; fetch saw if_stall_o and is re-presenting its next word.
         out_load   = 1'b1;
         instr_d    = skid_q_p1.instr;
         pc_d       = skid_q_p1.pc;
         pc4_d      = pc_plus4(skid_q_p1.pc);
         valid_d    = skid_q_p1.valid;
         skid_clear = 1'b1;
         state_d    = ST_FULL;
      end else begin
         out_load = 1'b1;
         if (if_valid) begin
            instr_d = if_instr;
            pc_d    = if_pc;
            pc4_d   = pc_plus4(if_pc);
            valid_d = 1'b1;
            state_d = ST_FULL;
         end else begin
            instr_d = NOP_INSTR;
            pc_d    = BUBBLE_PC;
            pc4_d   = pc_plus4(BUBBLE_PC);
            valid_d = 1'b0;
            state_d = ST_EMPTY;
         end
      end
   end

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- ID output register ----
   // Output register; reset forces a visible bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_instr <= NOP_INSTR;
         id_pc    <= BUBBLE_PC;
         id_pc4   <= pc_plus4(BUBBLE_PC);
         id_valid <= 1'b0;
      end else if (out_load) begin
         id_instr <= instr_d;
         id_pc    <= pc_d;
         id_pc4   <= pc4_d;
         id_valid <= valid_d;
      end
   end

`ifdef IFID_PERF_CNT_EN
   // Stall cycles and bubble loads, wrapping counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (id_stall && !id_flush) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (out_load && !valid_d) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed, table-driven bench for if_id_skid_reg. Each row is one clock:
// inputs applied before the edge, outputs checked 1 time unit after it.
module tb_if_id_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_instr, if_pc;
   logic        if_valid, id_stall, id_flush;
   logic        if_stall_o;
   logic [31:0] id_instr, id_pc, id_pc4;
   logic        id_valid;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   if_id_skid_reg dut (
      .clk        (clk),
      .rst        (rst),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_valid   (if_valid),
      .if_stall_o (if_stall_o),
      .id_stall   (id_stall),
      .id_flush   (id_flush),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_pc4     (id_pc4),
      .id_valid   (id_valid)
`ifdef IFID_PERF_CNT_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pc;     // fetch PC; instruction word is mk_instr(pc)
      logic        iv;
      logic        st;
      logic        fl;
      logic        ev;     // expected id_valid
      logic [31:0] epc;    // expected id_pc (0 for bubbles)
      logic        es;     // expected if_stall_o
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return {16'hA5A5, pc[15:0]} ^ {pc[31:16], 16'h0000};
   endfunction

   task automatic add(input logic r, input logic [31:0] pc, input logic iv, input logic st,
                      input logic fl, input logic ev, input logic [31:0] epc, input logic es);
      vec_t v;
      v.rst = r; v.pc = pc; v.iv = iv; v.st = st; v.fl = fl;
      v.ev = ev; v.epc = epc; v.es = es;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] e_instr, e_pc4;
      int          exp_stall_cnt, exp_bubble_cnt;

      rst = 1'b1; if_instr = '0; if_pc = '0; if_valid = 1'b0;
      id_stall = 1'b0; id_flush = 1'b0;
      exp_stall_cnt = 0; exp_bubble_cnt = 0;

      //   rst  pc            iv st fl  ev epc           es
      add(1, 32'h0000_0000, 0, 0, 0,  0, 32'h0,        0);  // reset
      add(1, 32'h0000_0000, 1, 0, 0,  0, 32'h0,        0);
      add(0, 32'h0000_0000, 1, 0, 0,  1, 32'h0000_0000, 0); // straight flow
      add(0, 32'h0000_0004, 1, 0, 0,  1, 32'h0000_0004, 0);
      add(0, 32'h0000_0008, 1, 0, 0,  1, 32'h0000_0008, 0);
      add(0, 32'h0000_0010, 1, 0, 0,  1, 32'h0000_0010, 0); // 1-cycle stall
      add(0, 32'h0000_0014, 1, 1, 0,  1, 32'h0000_0010, 1);
      add(0, 32'h0000_0018, 1, 0, 0,  1, 32'h0000_0014, 0);
      add(0, 32'h0000_0018, 1, 0, 0,  1, 32'h0000_0018, 0);
      add(0, 32'h0000_001C, 1, 1, 0,  1, 32'h0000_0018, 1); // 3-cycle stall
      add(0, 32'h0000_0020, 1, 1, 0,  1, 32'h0000_0018, 1);
      add(0, 32'h0000_0020, 1, 1, 0,  1, 32'h0000_0018, 1);
      add(0, 32'h0000_0020, 1, 0, 0,  1, 32'h0000_001C, 0);
      add(0, 32'h0000_0020, 1, 0, 0,  1, 32'h0000_0020, 0);
      add(0, 32'h0000_0024, 0, 0, 0,  0, 32'h0,        0);  // fetch bubble
      add(0, 32'h0000_0028, 1, 0, 0,  1, 32'h0000_0028, 0); // flush in SKID
      add(0, 32'h0000_002C, 1, 1, 0,  1, 32'h0000_0028, 1);
      add(0, 32'h0000_0030, 1, 1, 1,  0, 32'h0,        0);
      add(0, 32'h0000_0030, 1, 0, 0,  1, 32'h0000_0030, 0);
      add(0, 32'h0000_0034, 1, 1, 0,  1, 32'h0000_0030, 1); // reset mid-stall
      add(1, 32'h0000_0038, 1, 1, 0,  0, 32'h0,        0);
      add(0, 32'hFFFF_FFFC, 1, 0, 0,  1, 32'hFFFF_FFFC, 0); // pc4 wrap
      add(0, 32'h0000_003C, 0, 0, 0,  0, 32'h0,        0);  // EMPTY
      add(0, 32'h0000_0040, 1, 1, 0,  0, 32'h0,        1);  // EMPTY + stall captures
      add(0, 32'h0000_0044, 1, 0, 0,  1, 32'h0000_0040, 0);
      add(0, 32'h0000_0044, 1, 0, 0,  1, 32'h0000_0044, 0);
      add(0, 32'h0000_0048, 0, 1, 0,  1, 32'h0000_0044, 0); // stall, nothing fetched
      add(0, 32'h0000_0048, 1, 0, 0,  1, 32'h0000_0048, 0);
      add(0, 32'h0000_004C, 1, 0, 1,  0, 32'h0,        0);  // flush, no stall

      for (int i = 0; i < vecs.size(); i++) begin
         rst      = vecs[i].rst;
         if_pc    = vecs[i].pc;
         if_instr = mk_instr(vecs[i].pc);
         if_valid = vecs[i].iv;
         id_stall = vecs[i].st;
         id_flush = vecs[i].fl;
         @(posedge clk);
         #1;
         if (vecs[i].ev) begin
            e_instr = mk_instr(vecs[i].epc);
            e_pc4   = vecs[i].epc + 32'd4;
         end else begin
            e_instr = NOP;
            e_pc4   = 32'd4;
         end
         chk($sformatf("v%0d id_valid", i),   {31'd0, id_valid},   {31'd0, vecs[i].ev});
         chk($sformatf("v%0d id_instr", i),   id_instr,            e_instr);
         chk($sformatf("v%0d id_pc", i),      id_pc,               vecs[i].epc);
         chk($sformatf("v%0d id_pc4", i),     id_pc4,              e_pc4);
         chk($sformatf("v%0d if_stall_o", i), {31'd0, if_stall_o}, {31'd0, vecs[i].es});
         if (vecs[i].rst) begin
            exp_stall_cnt  = 0;
            exp_bubble_cnt = 0;
         end else begin
            if (vecs[i].st && !vecs[i].fl) exp_stall_cnt++;
            if (!(vecs[i].st && !vecs[i].fl) && !vecs[i].ev) exp_bubble_cnt++;
         end
`ifdef IFID_PERF_CNT_EN
         chk($sformatf("v%0d perf_stall_cnt", i),  perf_stall_cnt,  32'(exp_stall_cnt));
         chk($sformatf("v%0d perf_bubble_cnt", i), perf_bubble_cnt, 32'(exp_bubble_cnt));
`endif
      end

`ifdef IFID_PERF_CNT_EN
      // Hand sequence: reset, 3 stall cycles, 1 flush.
      rst = 1'b1; id_stall = 1'b0; id_flush = 1'b0; if_valid = 1'b1;
      if_pc = 32'h100; if_instr = mk_instr(32'h100);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;                       // loads 0x100
      id_stall = 1'b1; if_pc = 32'h104; if_instr = mk_instr(32'h104);
      repeat (3) begin @(posedge clk); #1; end
      id_stall = 1'b0; id_flush = 1'b1;
      @(posedge clk); #1;
      id_flush = 1'b0;
      chk("perf seq stall_cnt",  perf_stall_cnt,  32'd3);
      chk("perf seq bubble_cnt", perf_bubble_cnt, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline boundary register, directly downstream of the fetch stage.
- Registers the fetched instruction and PC for decode, and inserts NOP bubbles on flush.
- Absorbs decode back-pressure with a one-entry skid buffer, so the stall sent to fetch is purely registered (no combinational stall path from ID to imem).

Parameters:
- XLEN, 32, width of the PC and instruction datapath.
- NOP_INSTR, 32'h00000013, instruction word driven on bubble/flush (addi x0,x0,0).
- BUBBLE_PC, 32'h00000000, PC value driven with a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_instr  in  XLEN  instruction from the fetch stage.
- if_pc  in  XLEN  PC of if_instr.
- if_valid  in  1  if_instr/if_pc carry a real instruction (0 on fetch flush).
- if_stall_o  out  1  stall request to fetch; equals skid_valid (registered only).
- id_stall  in  1  decode/hazard stall; ID cannot accept a new instruction this cycle.
- id_flush  in  1  branch/jump redirect; kill the register contents and the skid entry.
- id_instr  out  XLEN  instruction to decode.
- id_pc  out  XLEN  PC of id_instr.
- id_pc4  out  XLEN  id_pc + 4, mod 2^XLEN, registered alongside id_pc.
- id_valid  out  1  id_instr is real.

Behaviour:
- State is defined by two flags, out_valid and skid_valid. The FSM is:
  - EMPTY: out_valid=0, skid_valid=0.
  - FULL: out_valid=1, skid_valid=0.
  - SKID: out_valid=1, skid_valid=1.
- Reset (rst=1 at a clock edge), from any state including mid-stall:
  - id_valid=0, id_instr=NOP_INSTR, id_pc=BUBBLE_PC, id_pc4=BUBBLE_PC+4.
  - skid_valid=0, if_stall_o=0; state becomes EMPTY.
- Priority each cycle is rst > id_flush > id_stall > normal advance.
- id_flush=1:
  - Output register loads the bubble values (id_valid=0, NOP_INSTR, BUBBLE_PC, BUBBLE_PC+4).
  - skid_valid <= 0; state becomes EMPTY.
  - Incoming if_* is discarded. Flush wins over a simultaneous id_stall.
- id_stall=1, skid empty:
  - Output register holds.
  - If if_valid=1, if_instr/if_pc are captured into the skid and skid_valid <= 1; the state moves to SKID only when it was FULL.
  - If if_valid=0, nothing is captured.
- id_stall=1, skid full: everything holds. Fetch is already stalled (if_stall_o=1), so the if_* inputs are ignored.
- id_stall=0, skid full: output register loads the skid entry (valid=1), skid_valid <= 0, and if_* is ignored this cycle.
- id_stall=0, skid empty: output register loads if_instr/if_pc with id_valid <= if_valid. When if_valid=0, NOP_INSTR/BUBBLE_PC are loaded.
- Latency and throughput:
  - Latency if_* -> id_* is 1 cycle with no stall.
  - A skidded instruction reaches ID in the first cycle after id_stall falls.
  - Throughput is 1 instruction/cycle; no instruction is lost or duplicated across any stall pattern.
- if_stall_o rises the cycle after the first stall cycle that captured an instruction. It falls the cycle after the skid drains.
- id_pc4 wraps: 32'hFFFFFFFC -> 32'h00000000.
- EMPTY with id_stall=1 and if_valid=1 captures into the skid but leaves out_valid=0. This corner is allowed; the skid drains on the next non-stall cycle.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0 and wrapping mod 2^32.
  - perf_stall_cnt increments on every non-reset cycle with id_stall=1 and id_flush=0.
  - perf_bubble_cnt increments on every non-reset cycle in which the output register loads id_valid=0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds XLEN, NOP_INSTR, BUBBLE_PC, and a struct/bundle of {instr, pc, valid} reused by later stage registers.
- One natural sub-module: pipe_skid_entry (single holding register with load/clear/valid), instantiated for the skid. The output register is inline.

Test Plan:
- Straight flow: PCs 0x0,0x4,0x8 with if_valid=1 and no stall -> id_pc 0x0,0x4,0x8 one cycle later each; id_pc4 0x4,0x8,0xC; if_stall_o always 0.
- Single-cycle stall at PC 0x10, next PC 0x14 -> id_pc holds 0x10 for 2 cycles; 0x14 is skidded, if_stall_o=1 for 1 cycle; next id_pc is 0x14 with no loss or duplicate.
- Three-cycle stall -> skid captures exactly one PC; if_stall_o=1 until the skid drains; output order is preserved.
- Flush while in SKID with id_stall=1 -> next cycle id_valid=0, id_instr=0x00000013, id_pc=0x0, if_stall_o=0; the skid entry is never emitted.
- Reset asserted mid-stall with skid full -> next cycle all outputs at reset values, if_stall_o=0. PC 0xFFFFFFFC -> id_pc4=0x0.
- With IFID_PERF_CNT_EN: 3 stall cycles + 1 flush -> perf_stall_cnt=3, perf_bubble_cnt=1, plus any reset-period bubbles counted after rst deasserts.
